test_port_writer: RTL and testbench

//  Drives the test-port write interface as the CPU would, for standalone testing of the result checker.
//  On start it writes BEGIN_SYMBOL, then NUM_WORDS payload words taken from a valid/ready stream, then END_SYMBOL.

---
 rtl/test_port_writer_pkg.sv | 38 +++
 rtl/test_port_pacer.sv | 57 +++++
 rtl/test_port_writer.sv | 158 +++++++++++++++
 tb/tb_test_port_writer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_port_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : test_port_writer_pkg
//  Purpose: Shared constants and encodings for the test-port writer. These are
//           the same values the result checker decodes on the addr/data/wen bus.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package test_port_writer_pkg;

  localparam logic [29:0] c_TEST_PORT    = 30'h40;
  localparam logic [31:0] c_BEGIN_SYMBOL = 32'h0000_0932;
  localparam logic [31:0] c_END_SYMBOL   = 32'h0000_0D5D;
  localparam int          c_NUM_WORDS    = 32;
  localparam int          c_WEN_HOLD     = 1;
  localparam int          c_GAP_CYCLES   = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_WRITE     = 3'd2,
    S_GAP       = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  // Selects which word a write carries and where the gap leads afterwards.
  typedef enum logic [1:0] {
    K_BEGIN = 2'd0,
    K_PAY   = 2'd1,
    K_END   = 2'd2
  } kind_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_port_pacer.sv
`default_nettype none
// ============================================================================
//  Module : test_port_pacer
//  Purpose: Hold/gap timer for the test-port writer. Loaded with the number of
//           cycles a phase lasts; expire_o marks the final cycle of the phase.
//  Ports  : clk_i       clock
//           rst_i       synchronous active-low reset
//           load_hold_i start a write phase of WEN_HOLD cycles
//           load_gap_i  start a gap phase of GAP_CYCLES cycles
//           stall_i     freeze the running phase (caller gates it to writes)
//           expire_o    current cycle is the last one of the phase
//  Rev    : 1.0  initial release
// ============================================================================
module test_port_pacer
  import test_port_writer_pkg::*;
#(
  parameter int WEN_HOLD   = c_WEN_HOLD,
  parameter int GAP_CYCLES = c_GAP_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_hold_i,
  input  logic load_gap_i,
  input  logic stall_i,
  output logic expire_o
);

  localparam int CW = $clog2(max2(WEN_HOLD, GAP_CYCLES)) + 1;
  localparam logic [CW-1:0] c_HOLD_LAST = CW'(WEN_HOLD - 1);
  localparam logic [CW-1:0] c_GAP_LAST  = CW'(GAP_CYCLES - 1);

  // Remaining cycles after the current one; zero means this cycle ends the phase.
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_hold_i) begin
      cnt_d = c_HOLD_LAST;
    end else if (load_gap_i) begin
      cnt_d = c_GAP_LAST;
    end else if (!stall_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign expire_o = (cnt_q == '0) && !stall_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_port_writer.sv
`default_nettype none
// ============================================================================
//  Module : test_port_writer
//  Purpose: Emulates CPU writes to the test port: BEGIN_SYMBOL, NUM_WORDS
//           payload words from a valid/ready stream, then END_SYMBOL. Every
//           write is a wen pulse followed by a wen-low gap.
//  Ports  : clk_i       clock
//           rst_i       synchronous active-low reset
//           start_i     begin a frame (taken in idle or done only)
//           stall_i     freezes an in-progress write
//           in_valid_i  payload word valid
//           in_data_i   payload word
//           in_ready_o  payload word accepted on in_valid_i && in_ready_o
//           addr_o      TEST_PORT while wen_o, else 0
//           data_o      word being written while wen_o, else 0
//           wen_o       write enable
//           busy_o      frame in progress
//           done_o      frame complete
//           word_cnt_o  payload words written in the current frame
//  Rev    : 1.0  initial release
// ============================================================================
module test_port_writer
  import test_port_writer_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = c_TEST_PORT,
  parameter logic [31:0] BEGIN_SYMBOL = c_BEGIN_SYMBOL,
  parameter logic [31:0] END_SYMBOL   = c_END_SYMBOL,
  parameter int          NUM_WORDS    = c_NUM_WORDS,
  parameter int          WEN_HOLD     = c_WEN_HOLD,
  parameter int          GAP_CYCLES   = c_GAP_CYCLES,
  parameter int          CNT_W        = $clog2(NUM_WORDS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_data_i,
  output logic             in_ready_o,
  output logic [29:0]      addr_o,
  output logic [31:0]      data_o,
  output logic             wen_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_WORDS);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic load_hold, load_gap, expire;

  // Stall only freezes writes; gaps run to completion regardless.
  test_port_pacer #(
    .WEN_HOLD   (WEN_HOLD),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_pacer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_hold_i (load_hold),
    .load_gap_i  (load_gap),
    .stall_i     (stall_i && (state_q == S_WRITE)),
    .expire_o    (expire)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    data_d     = data_q;
    word_cnt_d = word_cnt_q;
    load_hold  = 1'b0;
    load_gap   = 1'b0;
    in_ready_o = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_WRITE;
          kind_d     = K_BEGIN;
          data_d     = BEGIN_SYMBOL;
          word_cnt_d = '0;
          load_hold  = 1'b1;
        end
      end

      S_WAIT_DATA: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d   = S_WRITE;
          kind_d    = K_PAY;
          data_d    = in_data_i;
          load_hold = 1'b1;
        end
      end

      S_WRITE: begin
        if (expire) begin
          state_d  = S_GAP;
          load_gap = 1'b1;
          if (kind_q == K_PAY) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (expire) begin
          unique case (kind_q)
            K_BEGIN: state_d = S_WAIT_DATA;
            K_PAY: begin
              if (word_cnt_q == c_LAST_CNT) begin
                state_d   = S_WRITE;
                kind_d    = K_END;
                data_d    = END_SYMBOL;
                load_hold = 1'b1;
              end else begin
                state_d = S_WAIT_DATA;
              end
            end
            K_END:   state_d = S_DONE;
            default: state_d = S_IDLE;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      kind_q     <= K_BEGIN;
      data_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      data_q     <= data_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Bus is driven only while a write is in progress so the checker sees
  // clean zeros between writes.
  assign wen_o      = (state_q == S_WRITE);
  assign addr_o     = wen_o ? TEST_PORT : '0;
  assign data_o     = wen_o ? data_q : '0;
  assign busy_o     = (state_q == S_WAIT_DATA) || (state_q == S_WRITE) || (state_q == S_GAP);
  assign done_o     = (state_q == S_DONE);
  assign word_cnt_o = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_test_port_writer.sv
`default_nettype none
// ============================================================================
//  Module : tb_test_port_writer
//  Purpose: Directed self-checking bench for test_port_writer (default build)
//           and a short-frame build with WEN_HOLD=3, GAP_CYCLES=2, NUM_WORDS=4.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_test_port_writer;

  logic        clk;
  logic        rst_i;
  logic        start_i, stall_i, in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o, wen_o, busy_o, done_o;
  logic [29:0] addr_o;
  logic [31:0] data_o;
  logic [5:0]  word_cnt_o;

  logic        b_start, b_stall, b_in_valid;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_wen, b_busy, b_done;
  logic [29:0] b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_word_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] payload [32];

  test_port_writer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .addr_o(addr_o), .data_o(data_o), .wen_o(wen_o), .busy_o(busy_o),
    .done_o(done_o), .word_cnt_o(word_cnt_o)
  );

  test_port_writer #(.NUM_WORDS(4), .WEN_HOLD(3), .GAP_CYCLES(2)) dut6 (
    .clk_i(clk), .rst_i(rst_i), .start_i(b_start), .stall_i(b_stall),
    .in_valid_i(b_in_valid), .in_data_i(b_in_data), .in_ready_o(b_in_ready),
    .addr_o(b_addr), .data_o(b_data), .wen_o(b_wen), .busy_o(b_busy),
    .done_o(b_done), .word_cnt_o(b_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus monitor, default build ----------------
  logic [31:0] mon_words[$];
  int mon_pulses = 0, mon_hi = 0, mon_max_hi = 0;
  int mon_data_chg = 0, mon_addr_err = 0, mon_idle_err = 0;
  logic mon_prev = 1'b0;

  always @(negedge clk) begin
    if (wen_o) begin
      if (!mon_prev) begin
        mon_pulses++;
        mon_words.push_back(data_o);
        mon_hi = 1;
      end else begin
        mon_hi++;
        if (data_o !== mon_words[$]) mon_data_chg++;
      end
      if (mon_hi > mon_max_hi) mon_max_hi = mon_hi;
      if (addr_o !== 30'h40) mon_addr_err++;
    end else if (addr_o !== 30'h0 || data_o !== 32'h0) begin
      mon_idle_err++;
    end
    mon_prev = wen_o;
  end

  // ---------------- bus monitor, short-frame build ----------------
  logic [31:0] b_words[$];
  int b_pulses = 0, b_hi = 0, b_lo = 0;
  int b_hi_min = 1000, b_hi_max = 0, b_lo_min = 1000;
  logic b_prev = 1'b0, b_seen_fall = 1'b0;

  always @(negedge clk) begin
    if (b_wen) begin
      if (!b_prev) begin
        if (b_seen_fall && b_lo < b_lo_min) b_lo_min = b_lo;
        b_pulses++;
        b_words.push_back(b_data);
        b_hi = 1;
      end else begin
        b_hi++;
      end
    end else begin
      if (b_prev) begin
        if (b_hi < b_hi_min) b_hi_min = b_hi;
        if (b_hi > b_hi_max) b_hi_max = b_hi;
        b_seen_fall = 1'b1;
        b_lo = 1;
      end else begin
        b_lo++;
      end
    end
    b_prev = b_wen;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_word(input int i);
    if (i == 0)  return 32'h0000_0932;
    if (i == 33) return 32'h0000_0D5D;
    return payload[i-1];
  endfunction

  function automatic int count_word_errs(input int base);
    int n = 0;
    for (int i = 0; i < 34; i++) begin
      if (base + i >= mon_words.size()) n++;
      else if (mon_words[base+i] !== exp_word(i)) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on the default build cycle by cycle.
  //  stall_pulse : pulse number (1 = BEGIN) whose first cycle starts a 5-cycle stall, 0 = none
  //  hole_word   : payload index before which in_valid drops for 10 cycles, -1 = none
  //  restart_cnt : word_cnt value at which start is pulsed during writes, -1 = none
  task automatic run_frame(input bit do_start, input int stall_pulse, input int hole_word,
                           input int restart_cnt, output int busy_cycles,
                           output int timed_out, output int hole_bad);
    int idx = 0, stall_left = 0, hole_left = 0, pulses = 0;
    bit hole_done = 1'b0, prevw = 1'b0, hs;
    busy_cycles = 0;
    hole_bad    = 0;
    if (do_start) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
    for (int cyc = 0; cyc < 2000 && !done_o; cyc++) begin
      if (busy_o) busy_cycles++;
      if (wen_o && !prevw) begin
        pulses++;
        if (stall_pulse > 0 && pulses == stall_pulse) stall_left = 5;
      end
      stall_i = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (hole_word >= 0 && !hole_done && idx == hole_word && in_ready_o) begin
        hole_left = 10;
        hole_done = 1'b1;
      end
      if (hole_left > 0) begin
        in_valid_i = 1'b0;
        if (!in_ready_o || wen_o) hole_bad++;
        hole_left--;
      end else begin
        in_valid_i = 1'b1;
      end
      in_data_i = payload[(idx < 32) ? idx : 31];
      start_i   = (restart_cnt >= 0 && wen_o && word_cnt_o == 6'(restart_cnt));
      hs        = in_valid_i && in_ready_o;
      prevw     = wen_o;
      tick();
      if (hs) idx++;
    end
    timed_out  = done_o ? 0 : 1;
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    stall_i    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b1;   // reset must win over a simultaneous start
    tick();
    tick();
    checks++;
    if ({wen_o, busy_o, done_o, in_ready_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl wen/busy/done/ready=%b expected 0000", {wen_o, busy_o, done_o, in_ready_o});
    end
    checks++;
    if (addr_o !== 30'h0 || data_o !== 32'h0) begin
      errors++; $display("FAIL reset_bus addr=%h data=%h expected 0/0", addr_o, data_o);
    end
    checks++;
    if (word_cnt_o !== 6'd0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL reset_cnt word_cnt=%0d b_busy=%b expected 0/0", word_cnt_o, b_busy);
    end
    start_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_basic();
    int base = mon_words.size(), p0 = mon_pulses, bc, to, hb;
    run_frame(1'b1, 0, -1, -1, bc, to, hb);
    checks++;
    if (to !== 0) begin errors++; $display("FAIL basic_timeout done=%b expected 1", done_o); end
    checks++;
    if (mon_pulses - p0 !== 34) begin errors++; $display("FAIL basic_pulses got %0d expected 34", mon_pulses - p0); end
    checks++;
    if (mon_words[base] !== 32'h932) begin errors++; $display("FAIL basic_first got %h expected 00000932", mon_words[base]); end
    checks++;
    if (mon_words[base+33] !== 32'hD5D) begin errors++; $display("FAIL basic_last got %h expected 00000d5d", mon_words[base+33]); end
    checks++;
    if (count_word_errs(base) !== 0) begin errors++; $display("FAIL basic_words bad=%0d expected 0", count_word_errs(base)); end
    checks++;
    if (bc !== 100) begin errors++; $display("FAIL basic_length got %0d expected 100", bc); end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || word_cnt_o !== 6'd32) begin
      errors++; $display("FAIL basic_done done=%b busy=%b cnt=%0d expected 1/0/32", done_o, busy_o, word_cnt_o);
    end
    checks++;
    if (mon_addr_err !== 0 || mon_idle_err !== 0) begin
      errors++; $display("FAIL basic_bus addr_err=%0d idle_err=%0d expected 0/0", mon_addr_err, mon_idle_err);
    end
  endtask

  task automatic test_stall();
    int base = mon_words.size(), p0 = mon_pulses, bc, to, hb;
    run_frame(1'b1, 4, -1, -1, bc, to, hb);
    checks++;
    if (mon_pulses - p0 !== 34) begin errors++; $display("FAIL stall_pulses got %0d expected 34", mon_pulses - p0); end
    checks++;
    if (mon_max_hi !== 6) begin errors++; $display("FAIL stall_hold got %0d expected 6", mon_max_hi); end
    checks++;
    if (mon_data_chg !== 0) begin errors++; $display("FAIL stall_data changes=%0d expected 0", mon_data_chg); end
    checks++;
    if (count_word_errs(base) !== 0 || bc !== 105) begin
      errors++; $display("FAIL stall_frame bad=%0d len=%0d expected 0/105", count_word_errs(base), bc);
    end
  endtask

  task automatic test_hole();
    int base = mon_words.size(), p0 = mon_pulses, bc, to, hb;
    run_frame(1'b1, 0, 4, -1, bc, to, hb);
    checks++;
    if (hb !== 0) begin errors++; $display("FAIL hole_ready bad_cycles=%0d expected 0", hb); end
    checks++;
    if (mon_pulses - p0 !== 34 || count_word_errs(base) !== 0) begin
      errors++; $display("FAIL hole_words pulses=%0d bad=%0d expected 34/0", mon_pulses - p0, count_word_errs(base));
    end
    checks++;
    if (bc !== 110) begin errors++; $display("FAIL hole_length got %0d expected 110", bc); end
  endtask

  task automatic test_mid_reset();
    int idx = 0, base, p0, bc, to, hb;
    bit hs;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int cyc = 0; cyc < 300 && word_cnt_o != 6'd7; cyc++) begin
      in_valid_i = 1'b1;
      in_data_i  = payload[idx];
      hs = in_ready_o;
      tick();
      if (hs) idx++;
    end
    checks++;
    if (word_cnt_o !== 6'd7) begin errors++; $display("FAIL midrst_reach cnt=%0d expected 7", word_cnt_o); end
    rst_i = 1'b0;
    tick();
    checks++;
    if ({wen_o, busy_o, done_o, in_ready_o} !== 4'b0000 || addr_o !== 30'h0 ||
        data_o !== 32'h0 || word_cnt_o !== 6'd0) begin
      errors++; $display("FAIL midrst_outputs wen=%b busy=%b done=%b rdy=%b addr=%h data=%h cnt=%0d expected all 0",
                         wen_o, busy_o, done_o, in_ready_o, addr_o, data_o, word_cnt_o);
    end
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    tick();
    base = mon_words.size();
    p0   = mon_pulses;
    run_frame(1'b1, 0, -1, -1, bc, to, hb);
    checks++;
    if (mon_pulses - p0 !== 34 || count_word_errs(base) !== 0 || bc !== 100) begin
      errors++; $display("FAIL midrst_fresh pulses=%0d bad=%0d len=%0d expected 34/0/100",
                         mon_pulses - p0, count_word_errs(base), bc);
    end
  endtask

  task automatic test_restart();
    int base = mon_words.size(), p0 = mon_pulses, bc, to, hb;
    run_frame(1'b1, 0, -1, 3, bc, to, hb);
    checks++;
    if (mon_pulses - p0 !== 34 || count_word_errs(base) !== 0 || bc !== 100) begin
      errors++; $display("FAIL busy_start pulses=%0d bad=%0d len=%0d expected 34/0/100",
                         mon_pulses - p0, count_word_errs(base), bc);
    end
    base = mon_words.size();
    p0   = mon_pulses;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1 || word_cnt_o !== 6'd0) begin
      errors++; $display("FAIL restart_state done=%b busy=%b cnt=%0d expected 0/1/0", done_o, busy_o, word_cnt_o);
    end
    checks++;
    if (wen_o !== 1'b1 || data_o !== 32'h932 || addr_o !== 30'h40) begin
      errors++; $display("FAIL restart_begin wen=%b data=%h addr=%h expected 1/00000932/00000040", wen_o, data_o, addr_o);
    end
    run_frame(1'b0, 0, -1, -1, bc, to, hb);
    checks++;
    if (mon_pulses - p0 !== 34 || count_word_errs(base) !== 0 || bc !== 100) begin
      errors++; $display("FAIL restart_frame pulses=%0d bad=%0d len=%0d expected 34/0/100",
                         mon_pulses - p0, count_word_errs(base), bc);
    end
  endtask

  task automatic test_params6();
    int idx = 0, bc = 0, bad = 0;
    bit hs;
    logic [31:0] exp6 [6];
    exp6[0] = 32'h932; exp6[1] = 32'd1; exp6[2] = 32'd2;
    exp6[3] = 32'd3;   exp6[4] = 32'd4; exp6[5] = 32'hD5D;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int cyc = 0; cyc < 200 && !b_done; cyc++) begin
      if (b_busy) bc++;
      b_in_valid = 1'b1;
      b_in_data  = 32'(idx + 1);
      hs = b_in_ready;
      tick();
      if (hs) idx++;
    end
    b_in_valid = 1'b0;
    checks++;
    if (b_pulses !== 6) begin errors++; $display("FAIL p6_pulses got %0d expected 6", b_pulses); end
    checks++;
    if (b_hi_min !== 3 || b_hi_max !== 3) begin
      errors++; $display("FAIL p6_high min=%0d max=%0d expected 3/3", b_hi_min, b_hi_max);
    end
    checks++;
    if (b_lo_min < 2) begin errors++; $display("FAIL p6_low min=%0d expected >=2", b_lo_min); end
    checks++;
    if (bc !== 34 || b_done !== 1'b1 || b_word_cnt !== 3'd4) begin
      errors++; $display("FAIL p6_length len=%0d done=%b cnt=%0d expected 34/1/4", bc, b_done, b_word_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      if (i >= b_words.size()) bad++;
      else if (b_words[i] !== exp6[i]) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL p6_words bad=%0d expected 0", bad); end
  endtask

  initial begin
    int f [16];
    f[0] = 0; f[1] = 1;
    for (int i = 2; i < 16; i++) f[i] = f[i-1] + f[i-2];
    for (int i = 0; i < 16; i++) begin
      payload[i]      = 32'(f[i]);
      payload[16 + i] = 32'(f[15 - i]);
    end
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    b_start = 1'b0; b_stall = 1'b0; b_in_valid = 1'b0; b_in_data = '0;

    test_reset();
    test_basic();
    test_stall();
    test_hole();
    test_mid_reset();
    test_restart();
    test_params6();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
